csr_file: RTL and testbench

Parametrised control/status register file for the stage-1 pipeline. Generalises the single tohost CSR into an addressed file: tohost, NUM_SCRATCH scratch registers, and optional 64-bit cycle/instret counters. Supports write/set/clear operations and a combinational read port. Sits beside the writeback stage; `csrd` keeps its existing meaning, the live tohost value.

---
 rtl/csr_pkg.sv | 26 ++
 rtl/csr_counter.sv | 23 ++
 rtl/csr_file.sv | 127 ++++++++++++
 tb/tb_csr_file.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR address map and csr_op encoding for csr_file and the stage-1 decoder.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_TOHOST       = 12'h51E;
  localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;
  localparam logic [11:0] CSR_CYCLE        = 12'hC00;
  localparam logic [11:0] CSR_TIME         = 12'hC01;
  localparam logic [11:0] CSR_INSTRET      = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
  localparam logic [11:0] CSR_TIMEH        = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH     = 12'hC82;

  // Counter addresses stay mapped (read-only) whether or not counters are built.
  function automatic logic csr_is_counter(input logic [11:0] addr);
    return (addr == CSR_CYCLE)  || (addr == CSR_TIME)  || (addr == CSR_INSTRET) ||
           (addr == CSR_CYCLEH) || (addr == CSR_TIMEH) || (addr == CSR_INSTRETH);
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running up-counter with synchronous clear; wraps naturally at 2^WIDTH.
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= r_value + WIDTH'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/csr_file.sv
// Addressed CSR file: tohost, scratch registers, optional cycle/instret counters.
// Define CSR_COUNTERS_EN to build the counters; otherwise counter addresses read 0.
module csr_file
  import csr_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_SCRATCH = 4,
  parameter int CNT_WIDTH   = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            csr_we,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic [XLEN-1:0] csrd
);

  logic [XLEN-1:0]      r_tohost;
  logic [XLEN-1:0]      r_scratch [NUM_SCRATCH];

  logic                 w_tohost_hit;
  logic                 w_scr_hit;
  logic [3:0]           w_scr_idx;
  logic                 w_ro_hit;
  logic                 w_rw_hit;
  logic                 w_commit;
  logic [XLEN-1:0]      w_old;
  logic [XLEN-1:0]      w_wdata;
  logic [XLEN-1:0]      w_rdata;
  logic [CNT_WIDTH-1:0] w_cycle;
  logic [CNT_WIDTH-1:0] w_instret;

  assign w_tohost_hit = (csr_addr == CSR_TOHOST);
  assign w_scr_idx    = csr_addr[3:0];
  assign w_scr_hit    = (csr_addr[11:4] == CSR_SCRATCH_BASE[11:4]) &&
                        ({1'b0, w_scr_idx} < 5'(NUM_SCRATCH));
  assign w_ro_hit     = csr_is_counter(csr_addr);
  assign w_rw_hit     = w_tohost_hit || w_scr_hit;

  assign csr_illegal  = !(w_rw_hit || w_ro_hit) || (csr_we && w_ro_hit);
  assign w_commit     = csr_we && !stall && !reset &&
                        (csr_op != CSR_OP_NONE) && w_rw_hit;

`ifdef CSR_COUNTERS_EN
  csr_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .value (w_cycle)
  );

  csr_counter #(.WIDTH(CNT_WIDTH)) u_instret (
    .clk   (clk),
    .reset (reset),
    .inc   (retire && !stall),
    .value (w_instret)
  );
`else
  logic w_unused_retire;
  assign w_unused_retire = retire;
  assign w_cycle         = '0;
  assign w_instret       = '0;
`endif

  // Current contents of the addressed RW register feed both the read mux and the ALU.
  always_comb begin
    w_old = '0;
    if (w_tohost_hit) begin
      w_old = r_tohost;
    end
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (w_scr_hit && (w_scr_idx == 4'(i))) begin
        w_old = r_scratch[i];
      end
    end
  end

  always_comb begin
    w_wdata = w_old;
    case (csr_op)
      CSR_OP_WRITE: w_wdata = wb_data;
      CSR_OP_SET:   w_wdata = w_old | wb_data;
      CSR_OP_CLEAR: w_wdata = w_old & ~wb_data;
      default:      w_wdata = w_old;
    endcase
  end

  // High halves carry CNT_WIDTH-XLEN bits, zero-extended into XLEN.
  always_comb begin
    w_rdata = w_old;
    case (csr_addr)
      CSR_CYCLE, CSR_TIME:   w_rdata = w_cycle[XLEN-1:0];
      CSR_INSTRET:           w_rdata = w_instret[XLEN-1:0];
      CSR_CYCLEH, CSR_TIMEH: w_rdata = XLEN'(w_cycle >> XLEN);
      CSR_INSTRETH:          w_rdata = XLEN'(w_instret >> XLEN);
      default:               w_rdata = w_old;
    endcase
  end

  assign csr_rdata = w_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tohost <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        r_scratch[i] <= '0;
      end
    end else if (w_commit) begin
      if (w_tohost_hit) begin
        r_tohost <= w_wdata;
      end
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (w_scr_hit && (w_scr_idx == 4'(i))) begin
          r_scratch[i] <= w_wdata;
        end
      end
    end
  end

  assign csrd = r_tohost;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file; counter checks follow CSR_COUNTERS_EN.
module tb_csr_file;
  import csr_pkg::*;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        stall    = 1'b0;
  logic        csr_we   = 1'b0;
  logic [1:0]  csr_op   = 2'b00;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] wb_data  = 32'h0;
  logic        retire   = 1'b0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] csrd;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_tohost;
  logic [31:0] m_scr [4];
  logic [63:0] n_cyc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) n_cyc <= 64'd0;
    else       n_cyc <= n_cyc + 64'd1;
  end

  csr_file dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .csr_we      (csr_we),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .wb_data     (wb_data),
    .retire      (retire),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .csrd        (csrd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] data, input logic st, input logic ret);
    csr_we   = we;
    csr_op   = op;
    csr_addr = addr;
    wb_data  = data;
    stall    = st;
    retire   = ret;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, CSR_OP_WRITE, CSR_TOHOST, 32'hAAAA5555, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b0, CSR_OP_NONE, CSR_TOHOST, 32'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (csrd !== 32'h0) begin
      n_fail++; $display("FAIL reset_csrd: got %h expected %h", csrd, 32'h0);
    end
    n_tests++;
    if (csr_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_tohost_read: got %h expected %h", csr_rdata, 32'h0);
    end
    csr_addr = CSR_CYCLE;
    #1;
    n_tests++;
    if (csr_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_cycle: got %h expected %h", csr_rdata, 32'h0);
    end
    reset = 1'b0;
    tick();
    n_tests++;
`ifdef CSR_COUNTERS_EN
    if (csr_rdata !== 32'h1) begin
      n_fail++; $display("FAIL cycle_after_release: got %h expected %h", csr_rdata, 32'h1);
    end
`else
    if (csr_rdata !== 32'h0) begin
      n_fail++; $display("FAIL cycle_after_release: got %h expected %h", csr_rdata, 32'h0);
    end
`endif
    m_tohost = 32'h0;
    for (int i = 0; i < 4; i++) m_scr[i] = 32'h0;
  endtask

  task automatic test_write();
    exp_t e;
    drive(1'b1, CSR_OP_WRITE, CSR_TOHOST, 32'hDEADBEEF, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (csr_rdata !== m_tohost || csr_illegal !== 1'b0) begin
      n_fail++; $display("FAIL write_no_bypass: got %h/%b expected %h/0", csr_rdata, csr_illegal, m_tohost);
    end
    m_tohost = 32'hDEADBEEF;
    sb_q.push_back('{CSR_TOHOST, m_tohost});
    tick();
    drive(1'b1, CSR_OP_WRITE, CSR_TOHOST, 32'h12345678, 1'b1, 1'b0);
    #1;
    e = sb_q.pop_front();
    n_tests++;
    if (csr_rdata !== e.val || csrd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_tohost: got %h/%h expected %h", csr_rdata, csrd, e.val);
    end
    tick();
    drive(1'b0, CSR_OP_NONE, CSR_TOHOST, 32'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (csrd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL stalled_write_lost: got %h expected %h", csrd, 32'hDEADBEEF);
    end
  endtask

  task automatic test_set_clear();
    logic [1:0]  ops [6];
    logic [31:0] dat [6];
    exp_t e;
    ops = '{CSR_OP_WRITE, CSR_OP_SET, CSR_OP_CLEAR, CSR_OP_SET, CSR_OP_CLEAR, CSR_OP_NONE};
    dat = '{32'h000000F0, 32'h0000000F, 32'h000000F0, 32'h0, 32'h0, 32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ops[i], CSR_SCRATCH_BASE, dat[i], 1'b0, 1'b0);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (csr_rdata !== e.val) begin
          n_fail++; $display("FAIL set_clear_step%0d: got %h expected %h", i, csr_rdata, e.val);
        end
      end
      case (ops[i])
        CSR_OP_WRITE: m_scr[0] = dat[i];
        CSR_OP_SET:   m_scr[0] = m_scr[0] | dat[i];
        CSR_OP_CLEAR: m_scr[0] = m_scr[0] & ~dat[i];
        default:      m_scr[0] = m_scr[0];
      endcase
      sb_q.push_back('{CSR_SCRATCH_BASE, m_scr[0]});
      tick();
    end
    drive(1'b0, CSR_OP_NONE, CSR_SCRATCH_BASE, 32'h0, 1'b0, 1'b0);
    #1;
    e = sb_q.pop_front();
    n_tests++;
    if (csr_rdata !== e.val || csr_rdata !== 32'h0000000F) begin
      n_fail++; $display("FAIL set_clear_final: got %h expected %h", csr_rdata, 32'h0000000F);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      drive(1'b1, CSR_OP_WRITE, CSR_SCRATCH_BASE + 12'(i), v, 1'b0, 1'b0);
      m_scr[i] = v;
      sb_q.push_back('{CSR_SCRATCH_BASE + 12'(i), v});
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      drive(1'b1, CSR_OP_WRITE, CSR_TOHOST, v, 1'b0, 1'b0);
      #1;
      if (i > 0) begin
        e = sb_q.pop_back();
        n_tests++;
        if (csr_rdata !== e.val || csrd !== e.val) begin
          n_fail++; $display("FAIL b2b_tohost%0d: got %h/%h expected %h", i, csr_rdata, csrd, e.val);
        end
      end
      m_tohost = v;
      sb_q.push_back('{CSR_TOHOST, v});
      tick();
    end
    drive(1'b0, CSR_OP_NONE, CSR_TOHOST, 32'h0, 1'b0, 1'b0);
    #1;
    e = sb_q.pop_back();
    n_tests++;
    if (csrd !== e.val) begin
      n_fail++; $display("FAIL b2b_tohost_last: got %h expected %h", csrd, e.val);
    end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      csr_addr = e.addr;
      #1;
      n_tests++;
      if (csr_rdata !== e.val || csr_illegal !== 1'b0) begin
        n_fail++; $display("FAIL b2b_scratch_%h: got %h expected %h", e.addr, csr_rdata, e.val);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] exp_cyc;
    drive(1'b1, CSR_OP_WRITE, CSR_CYCLE, 32'hFFFFFFFF, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (csr_illegal !== 1'b1) begin
      n_fail++; $display("FAIL ro_write_illegal: got %b expected 1", csr_illegal);
    end
    tick();
    drive(1'b0, CSR_OP_NONE, CSR_CYCLE, 32'h0, 1'b0, 1'b0);
    #1;
`ifdef CSR_COUNTERS_EN
    exp_cyc = n_cyc[31:0];
`else
    exp_cyc = 32'h0;
`endif
    n_tests++;
    if (csr_rdata !== exp_cyc || csr_illegal !== 1'b0) begin
      n_fail++; $display("FAIL cycle_after_ro_write: got %h/%b expected %h/0", csr_rdata, csr_illegal, exp_cyc);
    end
    drive(1'b0, CSR_OP_NONE, 12'h123, 32'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (csr_rdata !== 32'h0 || csr_illegal !== 1'b1) begin
      n_fail++; $display("FAIL unmapped_read: got %h/%b expected 0/1", csr_rdata, csr_illegal);
    end
    drive(1'b1, CSR_OP_WRITE, CSR_SCRATCH_BASE + 12'd4, 32'h5A5A5A5A, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (csr_rdata !== 32'h0 || csr_illegal !== 1'b1) begin
      n_fail++; $display("FAIL scratch_oob: got %h/%b expected 0/1", csr_rdata, csr_illegal);
    end
    tick();
    drive(1'b1, CSR_OP_SET, CSR_INSTRETH, 32'h1, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (csr_illegal !== 1'b1) begin
      n_fail++; $display("FAIL ro_write_stalled: got %b expected 1", csr_illegal);
    end
    drive(1'b0, CSR_OP_NONE, CSR_TIMEH, 32'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (csr_illegal !== 1'b0) begin
      n_fail++; $display("FAIL ro_read_legal: got %b expected 0", csr_illegal);
    end
    for (int i = 0; i < 4; i++) begin
      csr_addr = CSR_SCRATCH_BASE + 12'(i);
      #1;
      n_tests++;
      if (csr_rdata !== m_scr[i] || csr_illegal !== 1'b0) begin
        n_fail++; $display("FAIL oob_no_alias%0d: got %h expected %h", i, csr_rdata, m_scr[i]);
      end
    end
  endtask

  task automatic test_instret();
    logic [31:0] exp_lo;
    reset = 1'b1;
    drive(1'b0, CSR_OP_NONE, CSR_INSTRET, 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    m_tohost = 32'h0;
    for (int i = 0; i < 4; i++) m_scr[i] = 32'h0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, CSR_OP_NONE, CSR_INSTRET, 32'h0, (i == 2 || i == 5 || i == 8), 1'b1);
      tick();
    end
    drive(1'b0, CSR_OP_NONE, CSR_INSTRET, 32'h0, 1'b0, 1'b0);
    #1;
`ifdef CSR_COUNTERS_EN
    exp_lo = 32'd7;
`else
    exp_lo = 32'd0;
`endif
    n_tests++;
    if (csr_rdata !== exp_lo) begin
      n_fail++; $display("FAIL instret_count: got %h expected %h", csr_rdata, exp_lo);
    end
    csr_addr = CSR_INSTRETH;
    #1;
    n_tests++;
    if (csr_rdata !== 32'h0) begin
      n_fail++; $display("FAIL instreth_zero: got %h expected %h", csr_rdata, 32'h0);
    end
  endtask

  task automatic test_wrap();
`ifdef CSR_COUNTERS_EN
    dut.u_cycle.r_value   = 64'h0000_0000_FFFF_FFFF;
    dut.u_instret.r_value = 64'h0000_0000_FFFF_FFFF;
    drive(1'b0, CSR_OP_NONE, CSR_CYCLE, 32'h0, 1'b0, 1'b1);
    #1;
    n_tests++;
    if (csr_rdata !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL wrap_pre_lo: got %h expected %h", csr_rdata, 32'hFFFFFFFF);
    end
    tick();
    retire = 1'b0;
    #1;
    n_tests++;
    if (csr_rdata !== 32'h0) begin
      n_fail++; $display("FAIL wrap_cycle_lo: got %h expected %h", csr_rdata, 32'h0);
    end
    csr_addr = CSR_CYCLEH;
    #1;
    n_tests++;
    if (csr_rdata !== 32'h1) begin
      n_fail++; $display("FAIL wrap_cycleh: got %h expected %h", csr_rdata, 32'h1);
    end
    csr_addr = CSR_INSTRETH;
    #1;
    n_tests++;
    if (csr_rdata !== 32'h1) begin
      n_fail++; $display("FAIL wrap_instreth: got %h expected %h", csr_rdata, 32'h1);
    end
`else
    drive(1'b0, CSR_OP_NONE, CSR_CYCLE, 32'h0, 1'b0, 1'b1);
    tick();
    #1;
    n_tests++;
    if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin
      n_fail++; $display("FAIL nocnt_cycle: got %h/%b expected 0/0", csr_rdata, csr_illegal);
    end
    csr_addr = CSR_CYCLEH;
    #1;
    n_tests++;
    if (csr_rdata !== 32'h0) begin
      n_fail++; $display("FAIL nocnt_cycleh: got %h expected %h", csr_rdata, 32'h0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    drive(1'b1, CSR_OP_WRITE, CSR_SCRATCH_BASE + 12'd1, 32'h0BADF00D, 1'b0, 1'b0);
    tick();
    drive(1'b1, CSR_OP_WRITE, CSR_TOHOST, 32'hCAFEF00D, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, CSR_OP_NONE, CSR_SCRATCH_BASE + 12'd1, 32'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (csrd !== 32'h0 || csr_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_state: got %h/%h expected 0/0", csrd, csr_rdata);
    end
    csr_addr = CSR_CYCLE;
    #1;
    n_tests++;
    if (csr_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_cycle: got %h expected %h", csr_rdata, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_set_clear();
    test_back_to_back();
    test_illegal();
    test_instret();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
